// File: rtl/vga_sync_monitor.sv
`default_nettype none
// =============================================================================
// vga_sync_monitor -- recovers row/col/active from HSync/VSync, checks timing
// Revision: 1.0
// =============================================================================
module vga_sync_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       HSync,
  input  logic       VSync,
  output logic [8:0] row,
  output logic [9:0] col,
  output logic       active,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_cnt
);

  localparam logic [9:0] c_CNT_MAX    = 10'd1023;
  localparam logic [9:0] c_CNT_PRE    = 10'd1022;
  localparam logic [9:0] c_H_SYNC_END = 10'(H_SYNC - 1);
  localparam logic [9:0] c_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_H_START    = 10'(H_SYNC + H_BP);
  localparam logic [9:0] c_H_STOP     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] c_V_SYNC_END = 10'(V_SYNC - 1);
  localparam logic [9:0] c_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_V_START    = 10'(V_SYNC + V_BP);
  localparam logic [9:0] c_V_STOP     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [1:0] c_GOOD_LOCK  = 2'd2;

  logic       hs_q, hs_d;
  logic       vs_line_q, vs_line_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vline_q, vline_d;
  logic       h_seen_q, h_seen_d;
  logic       v_seen_q, v_seen_d;
  logic [1:0] good_q, good_d;
  logic       frame_bad_q, frame_bad_d;
  logic       h_err_q, h_err_d;
  logic       v_err_q, v_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic w_hs_fall, w_hs_rise, w_v_fall, w_v_rise;
  logic w_h_lost, w_v_lost, w_h_in, w_v_in;

  always_comb begin
    w_hs_fall = hs_q & ~HSync;
    w_hs_rise = ~hs_q & HSync;
    w_v_fall  = w_hs_fall & vs_line_q & ~VSync;
    w_v_rise  = w_hs_fall & ~vs_line_q & VSync;
    w_h_lost  = (hcnt_q == c_CNT_MAX);
    w_v_lost  = (vline_q == c_CNT_MAX);

    hs_d      = HSync;
    hcnt_d    = w_hs_fall ? 10'd0 : (w_h_lost ? hcnt_q : hcnt_q + 10'd1);
    h_seen_d  = h_seen_q | w_hs_fall;
    // A saturated counter has already reported the loss; its late edge is not judged again.
    h_err_d   = (w_hs_rise && !w_h_lost && (hcnt_q != c_H_SYNC_END)) ||
                (w_hs_fall && h_seen_q && !w_h_lost && (hcnt_q != c_H_LAST)) ||
                (!w_hs_fall && (hcnt_q == c_CNT_PRE));

    vs_line_d = w_hs_fall ? VSync : vs_line_q;
    vline_d   = vline_q;
    if (w_v_fall)
      vline_d = 10'd0;
    else if (w_hs_fall && !w_v_lost)
      vline_d = vline_q + 10'd1;
    v_seen_d  = v_seen_q | w_v_fall;
    v_err_d   = (w_v_rise && !w_v_lost && (vline_q != c_V_SYNC_END)) ||
                (w_v_fall && v_seen_q && !w_v_lost && (vline_q != c_V_LAST)) ||
                (w_hs_fall && !w_v_fall && (vline_q == c_CNT_PRE));

    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    if (w_v_fall) begin
      frame_bad_d = 1'b0;
      if (v_seen_q)
        good_d = frame_bad_q ? 2'd0 : ((good_q == c_GOOD_LOCK) ? c_GOOD_LOCK : good_q + 2'd1);
    end
    if (h_err_d || v_err_d) begin
      good_d      = 2'd0;
      frame_bad_d = 1'b1;
    end

    err_cnt_d = ((h_err_q || v_err_q) && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q        <= 1'b1;
      vs_line_q   <= 1'b1;
      hcnt_q      <= 10'd0;
      vline_q     <= 10'd0;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      good_q      <= 2'd0;
      frame_bad_q <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      hs_q        <= hs_d;
      vs_line_q   <= vs_line_d;
      hcnt_q      <= hcnt_d;
      vline_q     <= vline_d;
      h_seen_q    <= h_seen_d;
      v_seen_q    <= v_seen_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign w_h_in  = (hcnt_q >= c_H_START) && (hcnt_q < c_H_STOP);
  assign w_v_in  = (vline_q >= c_V_START) && (vline_q < c_V_STOP);
  assign col     = w_h_in ? (hcnt_q - c_H_START) : 10'd0;
  assign row     = w_v_in ? 9'(vline_q - c_V_START) : 9'd0;
  assign locked  = (good_q == c_GOOD_LOCK);
  assign active  = locked & w_h_in & w_v_in;
  assign h_err   = h_err_q;
  assign v_err   = v_err_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// =============================================================================
// tb_vga_sync_monitor -- directed bench: scaled-timing DUT plus a default DUT
// Revision: 1.0
// =============================================================================
module tb_vga_sync_monitor;

  localparam int HT = 40, HS = 6, HB = 4, HA = 24;
  localparam int VT = 20, VS = 2, VB = 3, VA = 12;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic       clk = 1'b0;
  logic       rst, HSync, VSync;
  logic [8:0] row;
  logic [9:0] col;
  logic       active, locked, h_err, v_err;
  logic [7:0] err_cnt;

  logic       rst2, hs2, vs2;
  logic [8:0] d_row;
  logic [9:0] d_col;
  logic       d_active, d_locked, d_h_err, d_v_err;
  logic [7:0] d_err_cnt;

  int total = 0;
  int bad   = 0;

  int   f_herrs, f_verrs, f_pos_bad, f_max_col, f_max_row, f_nact;
  logic f_lock_first, f_lock_at_err;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .HSync(HSync), .VSync(VSync),
    .row(row), .col(col), .active(active), .locked(locked),
    .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
  );

  vga_sync_monitor dut_def (
    .clk(clk), .rst(rst2), .HSync(hs2), .VSync(vs2),
    .row(d_row), .col(d_col), .active(d_active), .locked(d_locked),
    .h_err(d_h_err), .v_err(d_v_err), .err_cnt(d_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic hs, input logic vs);
    HSync = hs;
    VSync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic hs, input logic vs);
    hs2 = hs;
    vs2 = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    HSync = 1'b1;
    VSync = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick(1'b1, 1'b1);
  endtask

  // One frame (or its first nlines lines); line odd_line gets its own length/sync width.
  task automatic run_frame(input int nlines, input int vs_lines, input int odd_line,
                           input int odd_len, input int odd_hsw, input bit chk, input bit exp_lock);
    int len, hsw, ce, re;
    logic ae;
    bit seen_err;
    f_herrs = 0; f_verrs = 0; f_pos_bad = 0; f_max_col = -1; f_max_row = -1; f_nact = 0;
    f_lock_first = 1'b0; f_lock_at_err = 1'b1; seen_err = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == odd_line) ? odd_len : HT;
      hsw = (l == odd_line) ? odd_hsw : HS;
      for (int i = 0; i < len; i++) begin
        tick(i >= hsw, l >= vs_lines);
        if (l == 0 && i == 0) f_lock_first = locked;
        if (h_err) f_herrs++;
        if (v_err) f_verrs++;
        if ((h_err || v_err) && !seen_err) begin
          seen_err = 1'b1;
          f_lock_at_err = locked;
        end
        if (active) begin
          f_nact++;
          if (int'(col) > f_max_col) f_max_col = int'(col);
          if (int'(row) > f_max_row) f_max_row = int'(row);
        end
        if (chk) begin
          ce = (i >= HST && i < HST + HA) ? i - HST : 0;
          re = (l >= VST && l < VST + VA) ? l - VST : 0;
          ae = exp_lock && (i >= HST) && (i < HST + HA) && (l >= VST) && (l < VST + VA);
          if (int'(col) != ce || int'(row) != re || active !== ae || locked !== exp_lock)
            f_pos_bad++;
        end
      end
    end
  endtask

  task automatic clean_frame(input bit chk, input bit exp_lock);
    run_frame(VT, VS, -1, HT, HS, chk, exp_lock);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (row !== 9'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", row); end
    total++; if (col !== 10'd0) begin bad++; $display("FAIL reset_col: got %0d want 0", col); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (h_err !== 1'b0) begin bad++; $display("FAIL reset_h_err: got %b want 0", h_err); end
    total++; if (v_err !== 1'b0) begin bad++; $display("FAIL reset_v_err: got %b want 0", v_err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    #3 rst = 1'b0;
    tick(1'b1, 1'b1);
  endtask

  task automatic test_nominal();
    int errs;
    errs = 0;
    clean_frame(1'b1, 1'b0);
    errs += f_herrs + f_verrs;
    total++; if (f_pos_bad != 0) begin bad++; $display("FAIL nom_f1_pos: got %0d bad cycles want 0", f_pos_bad); end
    clean_frame(1'b1, 1'b0);
    errs += f_herrs + f_verrs;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL nom_f2_end_locked: got %b want 0", locked); end
    clean_frame(1'b1, 1'b1);
    errs += f_herrs + f_verrs;
    total++; if (f_lock_first !== 1'b1) begin bad++; $display("FAIL nom_f3_lock_rise: got %b want 1", f_lock_first); end
    clean_frame(1'b1, 1'b1);
    errs += f_herrs + f_verrs;
    total++; if (f_pos_bad != 0) begin bad++; $display("FAIL nom_f4_pos: got %0d bad cycles want 0", f_pos_bad); end
    total++; if (f_max_col != HA - 1) begin bad++; $display("FAIL nom_max_col: got %0d want %0d", f_max_col, HA - 1); end
    total++; if (f_max_row != VA - 1) begin bad++; $display("FAIL nom_max_row: got %0d want %0d", f_max_row, VA - 1); end
    total++; if (f_nact != HA * VA) begin bad++; $display("FAIL nom_active_count: got %0d want %0d", f_nact, HA * VA); end
    total++; if (errs != 0) begin bad++; $display("FAIL nom_err_pulses: got %0d want 0", errs); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL nom_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_long_line();
    run_frame(VT, VS, 7, HT + 1, HS, 1'b0, 1'b0);
    total++; if (f_lock_first !== 1'b1) begin bad++; $display("FAIL long_pre_locked: got %b want 1", f_lock_first); end
    total++; if (f_herrs != 1) begin bad++; $display("FAIL long_h_err_pulses: got %0d want 1", f_herrs); end
    total++; if (f_lock_at_err !== 1'b0) begin bad++; $display("FAIL long_lock_drop: got %b want 0", f_lock_at_err); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL long_err_cnt: got %0d want 1", err_cnt); end
    clean_frame(1'b1, 1'b0);
    total++; if (f_pos_bad != 0) begin bad++; $display("FAIL long_f6_unlocked: got %0d bad cycles want 0", f_pos_bad); end
    clean_frame(1'b1, 1'b0);
    total++; if (f_pos_bad != 0) begin bad++; $display("FAIL long_f7_unlocked: got %0d bad cycles want 0", f_pos_bad); end
    clean_frame(1'b1, 1'b1);
    total++; if (f_lock_first !== 1'b1) begin bad++; $display("FAIL long_relock: got %b want 1", f_lock_first); end
    total++; if (f_pos_bad != 0) begin bad++; $display("FAIL long_f8_pos: got %0d bad cycles want 0", f_pos_bad); end
  endtask

  task automatic test_short_sync();
    run_frame(VT, VS, 3, HT, HS - 1, 1'b0, 1'b0);
    total++; if (f_herrs != 1) begin bad++; $display("FAIL short_h_err_pulses: got %0d want 1", f_herrs); end
    total++; if (f_nact != 0) begin bad++; $display("FAIL short_active_cycles: got %0d want 0", f_nact); end
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL short_err_cnt: got %0d want 2", err_cnt); end
    clean_frame(1'b1, 1'b0);
    total++; if (f_pos_bad != 0) begin bad++; $display("FAIL short_next_unlocked: got %0d bad cycles want 0", f_pos_bad); end
  endtask

  task automatic test_vsync_err();
    int verrs, herrs;
    apply_reset();
    repeat (3) clean_frame(1'b0, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL verr_pre_locked: got %b want 1", locked); end
    run_frame(VT, 3, -1, HT, HS, 1'b0, 1'b0);
    verrs = f_verrs; herrs = f_herrs;
    total++; if (f_verrs != 1) begin bad++; $display("FAIL verr_long_sync: got %0d want 1", f_verrs); end
    run_frame(VT - 1, VS, -1, HT, HS, 1'b0, 1'b0);
    verrs += f_verrs; herrs += f_herrs;
    clean_frame(1'b0, 1'b0);
    verrs += f_verrs; herrs += f_herrs;
    total++; if (verrs != 2) begin bad++; $display("FAIL verr_pulses: got %0d want 2", verrs); end
    total++; if (herrs != 0) begin bad++; $display("FAIL verr_h_pulses: got %0d want 0", herrs); end
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL verr_err_cnt: got %0d want 2", err_cnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL verr_locked: got %b want 0", locked); end
  endtask

  task automatic test_hsync_stuck();
    int pulses, first_n;
    pulses = 0; first_n = -1;
    for (int n = 1; n <= 1100; n++) begin
      tick(1'b1, 1'b1);
      if (h_err) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL stuck_pulses: got %0d want 1", pulses); end
    total++; if (first_n != 1023 - (HT - 1)) begin bad++; $display("FAIL stuck_when: got %0d want %0d", first_n, 1023 - (HT - 1)); end
    total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL stuck_err_cnt: got %0d want 3", err_cnt); end
    clean_frame(1'b0, 1'b0);
    total++; if (f_herrs + f_verrs != 0) begin bad++; $display("FAIL stuck_resume_errs: got %0d want 0", f_herrs + f_verrs); end
    total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL stuck_resume_cnt: got %0d want 3", err_cnt); end
  endtask

  task automatic test_reset_midframe();
    repeat (2) run_frame(VT, VS, 2, HT + 1, HS, 1'b0, 1'b0);
    repeat (2) clean_frame(1'b0, 1'b0);
    run_frame(8, VS, -1, HT, HS, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(i >= HS, 1'b1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked: got %b want 1", locked); end
    total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL mid_pre_err_cnt: got %0d want 5", err_cnt); end
    total++; if (active !== 1'b1 || col !== 10'd9 || row !== 9'd3) begin bad++; $display("FAIL mid_pre_pos: got act=%b col=%0d row=%0d want 1/9/3", active, col, row); end
    #2 rst = 1'b1;
    #1;
    total++; if ({row, col, active, locked, h_err, v_err, err_cnt} !== '0) begin bad++; $display("FAIL mid_async_clear: got row=%0d col=%0d act=%b lock=%b he=%b ve=%b cnt=%0d want all 0", row, col, active, locked, h_err, v_err, err_cnt); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick(1'b1, 1'b1);
    repeat (2) clean_frame(1'b0, 1'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_f2_locked: got %b want 0", locked); end
    clean_frame(1'b1, 1'b1);
    total++; if (f_lock_first !== 1'b1) begin bad++; $display("FAIL mid_relock: got %b want 1", f_lock_first); end
    for (int n = 0; n <= 300; n++) tick(n % 2 == 1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL mid_err_sat: got %0d want 255", err_cnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_err_locked: got %b want 0", locked); end
  endtask

  task automatic test_default();
    int nerr;
    hs2 = 1'b1; vs2 = 1'b1;
    @(posedge clk);
    #3 rst2 = 1'b0;
    nerr = 0;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < ((l == 2) ? 801 : 800); i++) begin
        tick2(i >= 96, 1'b1);
        if (d_h_err) nerr++;
        if (l == 1 && i == 143) begin total++; if (d_col !== 10'd0) begin bad++; $display("FAIL def_col_143: got %0d want 0", d_col); end end
        if (l == 1 && i == 145) begin total++; if (d_col !== 10'd1) begin bad++; $display("FAIL def_col_145: got %0d want 1", d_col); end end
        if (l == 1 && i == 783) begin total++; if (d_col !== 10'd639) begin bad++; $display("FAIL def_col_783: got %0d want 639", d_col); end end
        if (l == 1 && i == 784) begin total++; if (d_col !== 10'd0) begin bad++; $display("FAIL def_col_784: got %0d want 0", d_col); end end
      end
    end
    total++; if (nerr != 0) begin bad++; $display("FAIL def_clean_h_err: got %0d want 0", nerr); end
    tick2(1'b0, 1'b1);
    total++; if (d_h_err !== 1'b1) begin bad++; $display("FAIL def_801_h_err: got %b want 1", d_h_err); end
    tick2(1'b0, 1'b1);
    total++; if (d_err_cnt !== 8'd1) begin bad++; $display("FAIL def_err_cnt: got %0d want 1", d_err_cnt); end

    hs2 = 1'b1; vs2 = 1'b1;
    #2 rst2 = 1'b1;
    @(posedge clk);
    #3 rst2 = 1'b0;
    nerr = 0;
    for (int l = 0; l <= 525; l++) begin
      tick2(1'b0, l >= 2 && l < 525);
      if (d_v_err) nerr++;
      if (l == 35) begin total++; if (d_row !== 9'd0) begin bad++; $display("FAIL def_row_35: got %0d want 0", d_row); end end
      if (l == 36) begin total++; if (d_row !== 9'd1) begin bad++; $display("FAIL def_row_36: got %0d want 1", d_row); end end
      if (l == 514) begin total++; if (d_row !== 9'd479) begin bad++; $display("FAIL def_row_514: got %0d want 479", d_row); end end
      if (l == 515) begin total++; if (d_row !== 9'd0) begin bad++; $display("FAIL def_row_515: got %0d want 0", d_row); end end
      tick2(1'b1, l >= 2 && l < 525);
      if (d_v_err) nerr++;
    end
    total++; if (nerr != 0) begin bad++; $display("FAIL def_v_err: got %0d want 0", nerr); end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    HSync = 1'b1; VSync = 1'b1;
    hs2 = 1'b1; vs2 = 1'b1;
    test_reset();
    test_nominal();
    test_long_line();
    test_short_sync();
    test_vsync_err();
    test_hsync_stuck();
    test_reset_midframe();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
